// File: rtl/letc_core_pkg.sv
// Shared core types for the LETC data-memory subsystem.
// Holds the access-size enum, the TCM write-buffer entry and lane helpers.
package letc_core_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef struct packed {
    logic [29:0] word_idx;
    logic [3:0]  mask;
    logic [31:0] data;
  } dmss_wbuf_s;

  function automatic logic [3:0] dmss_byte_mask(
    input size_e      size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic dmss_misaligned(
    input size_e      size,
    input logic [1:0] lo
  );
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lo[0];
      SIZE_WORD: mis = |lo;
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] dmss_lane_data(
    input size_e       size,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {4{d[7:0]}};
      SIZE_HALF: r = {2{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/letc_core_dmss_tcm_sram.sv
// Behavioural single-port SRAM: byte-enable writes, registered read.
// Read data holds until the next read access.
module letc_core_dmss_tcm_sram #(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [3:0]                     i_be,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/letc_core_dmss_tcm.sv
// Data TCM responder: 1RW SRAM, one-entry write buffer with forwarding.
// Optional LR/SC reservation under LETC_DMSS_TCM_RESERVATION_EN.
module letc_core_dmss_tcm
  import letc_core_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_valid,
  input  logic [31:0] rd_addr,
  input  logic        rd_is_lr,
  output logic        rd_ready,
  input  logic        rd_flush,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_err,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  input  logic        wr_is_sc,
  output logic        sc_fail,
  output logic        wr_err
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [31:0]     w_rd_off;
  logic [31:0]     w_wr_off;
  logic            w_rd_oor;
  logic            w_wr_oor;
  logic [IDXW-1:0] w_rd_idx;
  logic [IDXW-1:0] w_wr_idx;
  size_e           w_size;
  logic            w_wr_go;
  logic            w_rd_acc;
  dmss_wbuf_s      w_wr_ent;

  assign w_rd_off = rd_addr - BASE_ADDR;
  assign w_wr_off = wr_addr - BASE_ADDR;
  assign w_rd_oor = {1'b0, w_rd_off} >= SPAN;
  assign w_wr_oor = {1'b0, w_wr_off} >= SPAN;
  assign w_rd_idx = w_rd_off[IDXW+1:2];
  assign w_wr_idx = w_wr_off[IDXW+1:2];
  assign w_size   = size_e'(wr_size);

  assign wr_err = wr_valid &&
    (w_wr_oor || dmss_misaligned(w_size, wr_addr[1:0]));

`ifdef LETC_DMSS_TCM_RESERVATION_EN
  logic            r_res_vld;
  logic [IDXW-1:0] r_res_idx;
  logic            w_res_hit;

  assign w_res_hit = r_res_vld && (r_res_idx == w_wr_idx);
  assign sc_fail   = wr_valid && wr_is_sc && !w_res_hit;

  // A newer LR wins over a same-cycle clear from the older write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_vld <= 1'b0;
      r_res_idx <= '0;
    end else if (w_rd_acc && rd_is_lr) begin
      r_res_vld <= !w_rd_oor;
      r_res_idx <= w_rd_idx;
    end else if (wr_valid && (wr_is_sc || (w_wr_go && w_res_hit))) begin
      r_res_vld <= 1'b0;
    end
  end
`else
  logic w_res_unused;
  assign w_res_unused = rd_is_lr ^ wr_is_sc;
  assign sc_fail      = 1'b0;
`endif

  assign w_wr_go = wr_valid && !wr_err && !sc_fail;

  assign w_wr_ent.word_idx = 30'(w_wr_idx);
  assign w_wr_ent.mask     = dmss_byte_mask(w_size, wr_addr[1:0]);
  assign w_wr_ent.data     = dmss_lane_data(w_size, wr_data);

  logic       r_wb_vld;
  dmss_wbuf_s r_wb;
  logic       w_wb_nxt_vld;
  dmss_wbuf_s w_wb_nxt;

  logic            w_sram_en;
  logic            w_sram_we;
  logic [IDXW-1:0] w_sram_idx;
  logic [3:0]      w_sram_be;
  logic [31:0]     w_sram_wd;
  logic [31:0]     w_sram_rd;

  // Only a read colliding with both a full buffer and a new write stalls
  assign rd_ready = !(rd_valid && r_wb_vld && w_wr_go);
  assign w_rd_acc = rd_valid && rd_ready;

  always_comb begin
    w_sram_en    = 1'b0;
    w_sram_we    = 1'b0;
    w_sram_idx   = w_rd_idx;
    w_sram_be    = 4'b0000;
    w_sram_wd    = 32'h0;
    w_wb_nxt_vld = r_wb_vld;
    w_wb_nxt     = r_wb;
    if (!rd_valid || !rd_ready) begin
      if (r_wb_vld) begin
        w_sram_en    = 1'b1;
        w_sram_we    = 1'b1;
        w_sram_idx   = r_wb.word_idx[IDXW-1:0];
        w_sram_be    = r_wb.mask;
        w_sram_wd    = r_wb.data;
        w_wb_nxt_vld = w_wr_go;
        if (w_wr_go) w_wb_nxt = w_wr_ent;
      end else if (w_wr_go) begin
        w_sram_en  = 1'b1;
        w_sram_we  = 1'b1;
        w_sram_idx = w_wr_idx;
        w_sram_be  = w_wr_ent.mask;
        w_sram_wd  = w_wr_ent.data;
      end
    end else begin
      w_sram_en = 1'b1;
      if (!r_wb_vld && w_wr_go) begin
        w_wb_nxt_vld = 1'b1;
        w_wb_nxt     = w_wr_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_wb_vld <= 1'b0;
    else        r_wb_vld <= w_wb_nxt_vld;
  end

  always_ff @(posedge clk) begin
    r_wb <= w_wb_nxt;
  end

  letc_core_dmss_tcm_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk    (clk),
    .i_en   (w_sram_en),
    .i_we   (w_sram_we),
    .i_idx  (w_sram_idx),
    .i_be   (w_sram_be),
    .i_wdata(w_sram_wd),
    .o_rdata(w_sram_rd)
  );

  logic            r_rsp_vld;
  logic            r_rsp_oor;
  logic [IDXW-1:0] r_rsp_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_oor <= 1'b0;
    end else begin
      r_rsp_vld <= w_rd_acc;
      if (w_rd_acc) r_rsp_oor <= w_rd_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) r_rsp_idx <= w_rd_idx;
  end

  assign load_valid = r_rsp_vld && !rd_flush;
  assign load_err   = r_rsp_vld && r_rsp_oor;

  // Buffer contents are newer than the SRAM word read last cycle
  logic w_fwd;
  assign w_fwd = r_wb_vld && (r_wb.word_idx[IDXW-1:0] == r_rsp_idx);

  always_comb begin
    load_data = w_sram_rd;
    for (int b = 0; b < 4; b++) begin
      if (w_fwd && r_wb.mask[b]) load_data[b*8 +: 8] = r_wb.data[b*8 +: 8];
    end
  end

  logic w_unused;
  assign w_unused = ^{w_rd_off, w_wr_off, r_wb.word_idx};

endmodule

// File: tb/tb_letc_core_dmss_tcm.sv
// Self-checking bench for letc_core_dmss_tcm: directed plan plus random traffic.
// Reference is a byte-array memory updated in program order.
module tb_letc_core_dmss_tcm;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned SPANB = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_is_lr = 1'b0;
  logic        rd_ready;
  logic        rd_flush = 1'b0;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_err;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [1:0]  wr_size = '0;
  logic [31:0] wr_data = '0;
  logic        wr_is_sc = 1'b0;
  logic        sc_fail;
  logic        wr_err;

  always #5 clk = ~clk;

  letc_core_dmss_tcm #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_is_lr  (rd_is_lr),
    .rd_ready  (rd_ready),
    .rd_flush  (rd_flush),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_err  (load_err),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_size   (wr_size),
    .wr_data   (wr_data),
    .wr_is_sc  (wr_is_sc),
    .sc_fail   (sc_fail),
    .wr_err    (wr_err)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [SPANB];
  bit          res_v = 1'b0;
  logic [31:0] res_w = '0;

  bit          pend = 1'b0;
  bit          pend_oor;
  logic [31:0] pend_exp;
  logic [31:0] last_data;
  bit          last_rdy;
  bit          last_werr;
  bit          last_scf;
  bit          last_lerr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SPANB;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned off;
    off = ((a - BASE) >> 2) << 2;
    return {mb[off+3], mb[off+2], mb[off+1], mb[off]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] s,
                             input logic [31:0] d, input bit sc,
                             output bit err, output bit scf);
    int unsigned off;
    bit mis;
    mis = (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
    err = mis || !in_range(a);
    scf = 1'b0;
`ifdef LETC_DMSS_TCM_RESERVATION_EN
    if (sc) begin
      scf   = !(res_v && res_w == (a >> 2));
      res_v = 1'b0;
    end
`endif
    if (!err && !scf) begin
      off = a - BASE;
      case (s)
        2'd0: mb[off] = d[7:0];
        2'd1: {mb[off+1], mb[off]} = d[15:0];
        default:
          for (int k = 0; k < 4; k++) mb[off+k] = d[8*k +: 8];
      endcase
`ifdef LETC_DMSS_TCM_RESERVATION_EN
      if (res_v && res_w == (a >> 2)) res_v = 1'b0;
`endif
    end
  endtask

  task automatic step(input bit rv, input logic [31:0] ra, input bit lr,
                      input bit fl, input bit wv, input logic [31:0] wa,
                      input logic [1:0] ws, input logic [31:0] wd,
                      input bit sc);
    bit e_err;
    bit e_scf;
    bit go;
    rd_valid = rv;
    rd_addr  = ra;
    rd_is_lr = lr;
    rd_flush = fl;
    wr_valid = wv;
    wr_addr  = wa;
    wr_size  = ws;
    wr_data  = wd;
    wr_is_sc = sc;
    @(negedge clk);
    if (pend) begin
      chk("load_valid", 32'(load_valid), 32'(!fl));
      if (!fl) begin
        chk("load_err", 32'(load_err), 32'(pend_oor));
        last_lerr = load_err;
        last_data = load_data;
        if (!pend_oor && !$isunknown(pend_exp))
          chk("load_data", load_data, pend_exp);
      end
    end else begin
      chk("load_valid_idle", 32'(load_valid), 32'd0);
    end
    pend = 1'b0;
    go   = 1'b0;
    if (wv) begin
      model_write(wa, ws, wd, sc, e_err, e_scf);
      chk("wr_err", 32'(wr_err), 32'(e_err));
      chk("sc_fail", 32'(sc_fail), 32'(e_scf));
      last_werr = wr_err;
      last_scf  = sc_fail;
      go = !e_err && !e_scf;
    end
    last_rdy = rd_ready;
    if (rv && !go) chk("rd_ready", 32'(rd_ready), 32'd1);
    if (rv && rd_ready) begin
      pend     = 1'b1;
      pend_oor = !in_range(ra);
      pend_exp = pend_oor ? 32'h0 : model_word(ra);
`ifdef LETC_DMSS_TCM_RESERVATION_EN
      if (lr && !pend_oor) begin
        res_v = 1'b1;
        res_w = ra >> 2;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit fl);
    step(0, 0, 0, fl, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1, a, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] s,
                    input logic [31:0] d);
    step(0, 0, 0, 0, 1, a, s, d, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_sc_fail", 32'(sc_fail), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) wr(32'h1000 + 32'(i * 4), 2'd2, $urandom);
    wr(32'h2000, 2'd2, 32'h0);
    idle(0);

    // 1: word store then read
    wr(32'h1000, 2'd2, 32'hCAFE_BABE);
    rd(32'h1000);
    idle(0);
    chk("t1_data", last_data, 32'hCAFE_BABE);

    // 2: same-cycle byte write and read of the same word
    wr(32'h1000, 2'd2, 32'h1122_3344);
    idle(0);
    step(1, 32'h1000, 0, 0, 1, 32'h1002, 2'd0, 32'h0000_00AA, 0);
    idle(0);
    chk("t2_data", last_data, 32'h11AA_3344);

    // 3: full buffer plus write plus read stalls the read
    step(1, 32'h1004, 0, 0, 1, 32'h1008, 2'd2, 32'h5566_7788, 0);
    step(1, 32'h1008, 0, 0, 1, 32'h1009, 2'd0, 32'h0000_0099, 0);
    chk("t3_stall", 32'(last_rdy), 32'd0);
    rd(32'h1008);
    chk("t3_accept", 32'(last_rdy), 32'd1);
    idle(0);
    chk("t3_data", last_data, 32'h5566_9988);

    // 4: misaligned half write and out-of-range read
    wr(32'h1001, 2'd1, 32'h0000_FFFF);
    chk("t4_werr", 32'(last_werr), 32'd1);
    rd(32'h1000);
    idle(0);
    chk("t4_unchanged", last_data, 32'h11AA_3344);
    rd(BASE + SPANB);
    idle(0);
    chk("t4_lerr", 32'(last_lerr), 32'd1);

    // 5: flushed response, then a normal one
    rd(32'h1000);
    idle(1);
    rd(32'h1000);
    idle(0);
    chk("t5_data", last_data, 32'h11AA_3344);

    // 6: LR / store / SC, then LR / SC
    step(1, 32'h2000, 1, 0, 0, 0, 0, 0, 0);
    wr(32'h2000, 2'd2, 32'h1234_5678);
    step(0, 0, 0, 0, 1, 32'h2000, 2'd2, 32'hDEAD_BEEF, 1);
`ifdef LETC_DMSS_TCM_RESERVATION_EN
    chk("t6_sc_fail", 32'(last_scf), 32'd1);
`else
    chk("t6_sc_plain", 32'(last_scf), 32'd0);
`endif
    rd(32'h2000);
    idle(0);
`ifdef LETC_DMSS_TCM_RESERVATION_EN
    chk("t6_nowrite", last_data, 32'h1234_5678);
`else
    chk("t6_plain", last_data, 32'hDEAD_BEEF);
`endif
    step(1, 32'h2000, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2000, 2'd2, 32'h0BAD_F00D, 1);
    chk("t6_sc_ok", 32'(last_scf), 32'd0);
    rd(32'h2000);
    idle(0);
    chk("t6_landed", last_data, 32'h0BAD_F00D);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      ra = 32'h1000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) ra = BASE + SPANB + 32'($urandom_range(0, 255));
      wa = 32'h1000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) wa = BASE + SPANB + 32'($urandom_range(0, 63));
      step($urandom_range(0, 1) == 1, ra, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, wa,
           2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 7) == 0);
    end
    idle(0);
    idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
